// File: rtl/rx_link_ctrl.sv
// Receive link-acquisition controller: finds the 10-bit word boundary using commas,
// requests bit slips while hunting, and drops lock when the windowed error count hits a limit.
module rx_link_ctrl #(
  parameter int unsigned LOCK_COMMAS = 4,
  parameter int unsigned HUNT_SYMS   = 16,
  parameter int unsigned ERR_LIMIT   = 8,
  parameter int unsigned WINDOW      = 256
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       symTick,
  input  logic       commaDet,
  input  logic       symErr,
  output logic       slip,
  output logic       linkUp,
  output logic       dataEn,
  output logic [1:0] state,
  output logic [7:0] errCount,
  output logic [3:0] lossCount
);

  localparam int unsigned HW = $clog2(HUNT_SYMS) + 1;
  localparam int unsigned CW = $clog2(LOCK_COMMAS) + 1;
  localparam int unsigned EW = $clog2(ERR_LIMIT) + 1;
  localparam int unsigned WW = $clog2(WINDOW) + 1;
  localparam int unsigned SW = 2;

  localparam logic [HW-1:0] HUNT_LAST = HW'(HUNT_SYMS - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_COMMAS - 1);
  localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SLIP   = 2'b01,
    VERIFY = 2'b10,
    LOCKED = 2'b11
  } state_t;

  state_t        cur, nxt;
  logic [HW-1:0] huntCnt, hunt_n;
  logic [CW-1:0] commaCnt, comma_n;
  logic [SW-1:0] settleCnt, settle_n;
  logic [WW-1:0] winCnt, win_n;
  logic [EW-1:0] winErr, werr_n;
  logic [7:0]    err_n;
  logic [3:0]    loss_n;
  logic          slip_n;

  always_comb begin
    nxt      = cur;
    hunt_n   = huntCnt;
    comma_n  = commaCnt;
    settle_n = settleCnt;
    win_n    = winCnt;
    werr_n   = winErr;
    err_n    = errCount;
    loss_n   = lossCount;
    if (symTick) begin
      unique case (cur)
        HUNT: begin
          if (commaDet) begin
            nxt     = VERIFY;
            comma_n = CW'(1);
          end else if (huntCnt == HUNT_LAST) begin
            nxt      = SLIP;
            hunt_n   = '0;
            settle_n = '0;
          end else begin
            hunt_n = huntCnt + HW'(1);
          end
        end
        SLIP: begin
          if (settleCnt == SW'(1)) begin
            nxt    = HUNT;
            hunt_n = '0;
          end else begin
            settle_n = settleCnt + SW'(1);
          end
        end
        VERIFY: begin
          if (symErr || !commaDet) begin
            nxt    = HUNT;
            hunt_n = '0;
          end else if (commaCnt == LOCK_LAST) begin
            nxt    = LOCKED;
            err_n  = '0;
            win_n  = '0;
            werr_n = '0;
          end else begin
            comma_n = commaCnt + CW'(1);
          end
        end
        LOCKED: begin
          if (symErr && errCount != '1) err_n = errCount + 8'd1;
          // an error on the window's last symbol still counts toward that window
          if (symErr && winErr == ERR_LAST) begin
            nxt    = HUNT;
            hunt_n = '0;
            if (lossCount != '1) loss_n = lossCount + 4'd1;
          end else if (winCnt == WIN_LAST) begin
            win_n  = '0;
            werr_n = '0;
          end else begin
            win_n = winCnt + WW'(1);
            if (symErr) werr_n = winErr + EW'(1);
          end
        end
        default: nxt = HUNT;
      endcase
    end
    slip_n = (cur != SLIP) && (nxt == SLIP);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cur       <= HUNT;
      huntCnt   <= '0;
      commaCnt  <= '0;
      settleCnt <= '0;
      winCnt    <= '0;
      winErr    <= '0;
      errCount  <= '0;
      lossCount <= '0;
      slip      <= 1'b0;
      linkUp    <= 1'b0;
    end else begin
      cur       <= nxt;
      huntCnt   <= hunt_n;
      commaCnt  <= comma_n;
      settleCnt <= settle_n;
      winCnt    <= win_n;
      winErr    <= werr_n;
      errCount  <= err_n;
      lossCount <= loss_n;
      slip      <= slip_n;
      linkUp    <= (nxt == LOCKED);
    end
  end

  assign state  = cur;
  assign dataEn = linkUp & symTick & ~commaDet & ~symErr;

endmodule

// File: doc/rx_link_ctrl.md
# rx_link_ctrl

Link-acquisition and monitoring controller for the SERDES receive path. It watches the per-symbol status produced by the RX datapath (symbol strobe, comma detect, decode/RD error) and decides when the 10-bit word boundary is aligned. When alignment is wrong it issues bit-slip requests, declares link-up after consecutive commas, and drops the link when the windowed error rate crosses a limit. It sits between the RX shift-register/decoder and the VGA data consumer, and gates capture with `dataEn`.

## Interface
- `LOCK_COMMAS`, default 4: consecutive commas required to declare lock (≥2).
- `HUNT_SYMS`, default 16: symbols without a comma before a slip is requested (≥2).
- `ERR_LIMIT`, default 8: errors within one window that cause loss of lock (≥1).
- `WINDOW`, default 256: length of the error-monitor window, in symbols (≥ERR_LIMIT).

- `clk`  in  1: system clock; the only clock.
- `resetN`  in  1: asynchronous, active-low reset.
- `symTick`  in  1: one-cycle strobe marking a completed 10-bit symbol; `commaDet`/`symErr` are valid only when it is high.
- `commaDet`  in  1: current symbol is a K28.5 comma of either disparity.
- `symErr`  in  1: current symbol is invalid or has a running-disparity error.
- `slip`  out  1: one-cycle pulse; the datapath shifts the word boundary by one bit.
- `linkUp`  out  1: high while in LOCKED.
- `dataEn`  out  1: `linkUp & symTick & ~commaDet & ~symErr`. This is the only combinational output.
- `state`  out  2: HUNT=00, SLIP=01, VERIFY=10, LOCKED=11.
- `errCount`  out  8: errors seen since the last lock; saturates at 255.
- `lossCount`  out  4: number of lock losses since reset; saturates at 15.

## Operation
- On reset: state=HUNT. All counters are 0. `slip`=0, `linkUp`=0, `errCount`=0, `lossCount`=0.
- All decisions are taken on a `clk` edge where `symTick`=1. With `symTick`=0, no counter changes, except the one-cycle `slip` pulse.
- HUNT:
  - `commaDet` → VERIFY with commaCnt=1.
  - Otherwise huntCnt++. When huntCnt would reach `HUNT_SYMS`, go to SLIP and clear huntCnt.
  - `symErr` is ignored in HUNT.
- SLIP:
  - `slip` is registered high for exactly the first clk cycle in SLIP.
  - Stay in SLIP for 2 `symTick`s (settle time). On the 2nd `symTick`, go to HUNT with huntCnt=0.
  - Comma and error inputs are ignored in SLIP.
- VERIFY, on each `symTick`:
  - `symErr`, or a non-comma symbol → HUNT, huntCnt=0.
  - `commaDet` → commaCnt++. When commaCnt reaches `LOCK_COMMAS`, go to LOCKED.
  - On entry to LOCKED, clear `errCount`, winCnt and winErr.
- LOCKED, on each `symTick`:
  - winCnt++ always.
  - If `symErr`: winErr++ and `errCount`++ (saturating).
  - If winErr reaches `ERR_LIMIT` → HUNT, `lossCount`++ (saturating), huntCnt=0.
  - When winCnt reaches `WINDOW`, clear both winCnt and winErr on the same edge.
  - Commas in LOCKED are legal idle symbols.
- Simultaneous events:
  - An error on the last symbol of a window counts toward that window. If it makes winErr=`ERR_LIMIT`, lock is lost before the window clear applies.
  - `errCount` is not cleared on loss of lock; it holds its value until the next entry to LOCKED.
- Internal counter widths are `$clog2` of their limit plus 1. No counter ever wraps.
- Reset asserted mid-operation, including during a `slip` pulse, forces the reset state immediately.

## Timing
- `state`, `linkUp`, `slip`, `errCount` and `lossCount` update on the clk edge that samples the deciding `symTick`.
- `linkUp` rises on the same edge on which `state` becomes LOCKED.
- `dataEn` is high in the same cycle as a qualifying `symTick`, starting with the first `symTick` after lock.
- Lock latency from the first comma: `LOCK_COMMAS` symbols.
- A slip occurs every `HUNT_SYMS`+2 symbols while no comma is present.
- `slip` is never high on two consecutive cycles.

## Test plan
- **Reset then idle commas.** Reset, then 4 consecutive comma symbols → VERIFY after the 1st, LOCKED and `linkUp`=1 after the 4th, `slip` never asserted.
- **No commas.** 16 non-comma symbols → one `slip` pulse 1 cycle wide. State is SLIP for 2 symbols, then HUNT. After 18 more non-comma symbols, a second pulse.
- **Broken verify.** 3 commas, then a data symbol → back to HUNT, `linkUp` stays 0. Then 4 commas → LOCKED.
- **Loss of lock.** Locked, then 8 `symErr` within 256 symbols → HUNT on the 8th error, `lossCount`=1, `errCount`=8, `linkUp`=0.
- **Window boundary.** Locked, 7 errors in symbols 1–255, an error on symbol 256 → lock lost. Alternatively, 7 errors in window 1 and 7 in window 2 → stays LOCKED, `errCount`=14.
- **Mid-operation reset.** Assert `resetN`=0 during the `slip` pulse and while LOCKED → all outputs 0 and state HUNT asynchronously. `lossCount` saturates at 15 after 16 forced losses.
